parking_queue: RTL and testbench

PARKING_QUEUE -- requirements
Module: parking_queue

---
 rtl/parking_queue.sv | 86 ++++++++
 tb/tb_parking_queue.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/parking_queue.sv
// rtl/parking_queue.sv - parking time-data FIFO with first-word-fall-through head and sticky error flags
module parking_queue #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enQ,
  input  logic [WIDTH-1:0]           data_Q,
  input  logic                       deq,
  input  logic                       clr_err,
  output logic [WIDTH-1:0]           q_data,
  output logic                       q_valid,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;

  logic full_w, empty_w, push_ok, pop_ok, ovf_evt, udf_evt;

  assign full_w  = (count_q == CW'(DEPTH));
  assign empty_w = (count_q == '0);

  // A full queue still takes a push when the same cycle pops, reusing the freed slot.
  assign push_ok = enQ && (!full_w || deq);
  assign pop_ok  = deq && !empty_w;
  assign ovf_evt = enQ && full_w && !deq;
  assign udf_evt = deq && empty_w;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // An error on the same edge as clr_err wins so no event is lost.
    ovf_d = (clr_err ? 1'b0 : ovf_q) | ovf_evt;
    udf_d = (clr_err ? 1'b0 : udf_q) | udf_evt;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok && !reset) mem_q[wr_ptr_q] <= data_Q;
  end

  assign q_data    = empty_w ? '0 : mem_q[rd_ptr_q];
  assign q_valid   = !empty_w;
  assign full      = full_w;
  assign empty     = empty_w;
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign underflow = udf_q;

endmodule

// File: tb/tb_parking_queue.sv
// tb/tb_parking_queue.sv - directed self-checking bench for parking_queue
module tb_parking_queue;

  logic       clock = 1'b0;
  logic       reset;
  logic       enQ, deq, clr_err;
  logic [7:0] data_Q;
  logic [7:0] q_data;
  logic       q_valid, full, empty, overflow, underflow;
  logic [3:0] count;

  int n_tests = 0;
  int n_fail  = 0;

  parking_queue #(.WIDTH(8), .DEPTH(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .enQ       (enQ),
    .data_Q    (data_Q),
    .deq       (deq),
    .clr_err   (clr_err),
    .q_data    (q_data),
    .q_valid   (q_valid),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic e, input logic [7:0] d, input logic p, input logic c);
    enQ = e; data_Q = d; deq = p; clr_err = c;
    @(posedge clock);
    #1;
    enQ = 1'b0; deq = 1'b0; clr_err = 1'b0; data_Q = 8'h00;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_count"}, 32'(count), 0);
    check({tag, "_empty"}, 32'(empty), 1);
    check({tag, "_full"},  32'(full), 0);
    check({tag, "_valid"}, 32'(q_valid), 0);
    check({tag, "_qdata"}, 32'(q_data), 0);
    check({tag, "_ovf"},   32'(overflow), 0);
    check({tag, "_udf"},   32'(underflow), 0);
  endtask

  initial begin
    logic [7:0] v3 [3];
    v3[0] = 8'hF2; v3[1] = 8'h15; v3[2] = 8'h7A;
    reset = 1'b1; enQ = 1'b0; deq = 1'b0; clr_err = 1'b0; data_Q = 8'h00;
    #2;
    check_reset_state("rst");
    @(posedge clock); #1;
    reset = 1'b0;

    // basic push/pop, first push on first edge after release
    for (int i = 0; i < 3; i++) cyc(1'b1, v3[i], 1'b0, 1'b0);
    check("b_count", 32'(count), 3);
    check("b_head",  32'(q_data), 32'hF2);
    check("b_valid", 32'(q_valid), 1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check("b_pop1", 32'(q_data), 32'h15);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check("b_pop2", 32'(q_data), 32'h7A);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check("b_empty", 32'(empty), 1);
    check("b_qdata0", 32'(q_data), 0);
    check("b_count0", 32'(count), 0);

    // fill, overflow, drain (pointers wrap)
    for (int i = 1; i <= 8; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
    check("f_full",  32'(full), 1);
    check("f_count", 32'(count), 8);
    cyc(1'b1, 8'h09, 1'b0, 1'b0);
    check("o_ovf",   32'(overflow), 1);
    check("o_count", 32'(count), 8);
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("o_pop%0d", i), 32'(q_data), 32'(i));
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
    end
    check("o_empty", 32'(empty), 1);
    check("o_ovf_sticky", 32'(overflow), 1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    check("o_clr", 32'(overflow), 0);

    // full with simultaneous push+pop
    for (int i = 1; i <= 8; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
    cyc(1'b1, 8'hAA, 1'b1, 1'b0);
    check("fp_count", 32'(count), 8);
    check("fp_head",  32'(q_data), 32'h02);
    check("fp_ovf",   32'(overflow), 0);
    for (int i = 2; i <= 8; i++) begin
      check($sformatf("fp_pop%0d", i), 32'(q_data), 32'(i));
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
    end
    check("fp_last", 32'(q_data), 32'hAA);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check("fp_empty", 32'(empty), 1);

    // underflow, clear, clear-vs-event priority
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check("u_udf",   32'(underflow), 1);
    check("u_count", 32'(count), 0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    check("u_clr",   32'(underflow), 0);
    cyc(1'b0, 8'h00, 1'b1, 1'b1);
    check("u_clr_evt", 32'(underflow), 1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    check("u_clr2",  32'(underflow), 0);

    // empty with simultaneous push+pop
    cyc(1'b1, 8'h33, 1'b1, 1'b0);
    check("ep_count", 32'(count), 1);
    check("ep_head",  32'(q_data), 32'h33);
    check("ep_udf",   32'(underflow), 1);

    // async reset mid-operation
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
    check("r_count5", 32'(count), 5);
    #3 reset = 1'b1;
    #1;
    check_reset_state("ar");
    @(posedge clock); #1;
    reset = 1'b0;
    cyc(1'b1, 8'h44, 1'b0, 1'b0);
    check("ar_count", 32'(count), 1);
    check("ar_head",  32'(q_data), 32'h44);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
